mul_nnbit_wallace_pipe: RTL and testbench

//  Parametrised, fully pipelined radix-4 Booth / Wallace-tree multiplier with valid/ready handshake
//  and per-operation signed/unsigned mode. Accepts one operation per cycle and produces a full 2W-bit product.

---
 rtl/mul_nnbit_wallace_pipe.sv | 217 +++++++++++++++++++++
 tb/tb_mul_nnbit_wallace_pipe.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_nnbit_wallace_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mul_nnbit_wallace_pipe                                           |
// | Purpose : Fully pipelined radix-4 Booth / Wallace-tree multiplier with a   |
// |           valid/ready handshake and per-operation signed/unsigned mode.    |
// |           One operation per cycle, exact 2W-bit product.                   |
// | Ports   : i_clk, i_rst_n (sync, active-low)                                |
// |           i_valid/o_ready      : input handshake                           |
// |           i_sign               : 1 = two's complement, 0 = unsigned        |
// |           i_num_x, i_num_y     : W-bit operands                            |
// |           o_valid/i_ready      : output handshake                          |
// |           o_res                : 2W-bit product                            |
// |           o_busy               : any pipeline stage holds an operation     |
// | Config  : MUL_NNBIT_WALLACE_PIPE_SPLIT_EN - when defined, the Wallace tree |
// |           is split by an extra register stage (latency 4 instead of 3).    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module mul_nnbit_wallace_pipe #(
  parameter int DATA_WIDTH = 16  // even, 4..64
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic                      i_sign,
  input  logic [DATA_WIDTH-1:0]     i_num_x,
  input  logic [DATA_WIDTH-1:0]     i_num_y,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [2*DATA_WIDTH-1:0]   o_res,
  output logic                      o_busy
);

  // Rows left after 'lvls' levels of 3:2 compression starting from 'r' rows.
  function automatic int rows_after(input int r, input int lvls);
    int c;
    c = r;
    for (int l = 0; l < lvls; l++) c = c - c / 3;
    return c;
  endfunction

  // Number of 3:2 levels needed to bring 'r' rows down to two.
  function automatic int levels_to_two(input int r);
    int c;
    int n;
    c = r;
    n = 0;
    while (c > 2) begin
      c = c - c / 3;
      n++;
    end
    return n;
  endfunction

  localparam int W        = DATA_WIDTH;
  localparam int PW       = 2 * W;
  localparam int NPP      = W / 2 + 1;       // Booth digits over the W+2 bit extension
  localparam int NROW     = NPP + 1;         // partial products plus the carry-in row
  localparam int NLVL     = levels_to_two(NROW);
  localparam int NLVL_A   = NLVL / 2;        // levels before the optional split register
  localparam int NROW_MID = rows_after(NROW, NLVL_A);

  typedef logic [NROW-1:0][PW-1:0] rows_t;

  // Row-parallel Wallace reduction: each level turns every group of three rows
  // into a sum row and a left-shifted carry row; leftover rows pass straight on.
  // Rows at or above the live count are kept at zero.
  function automatic rows_t compress(input rows_t in_rows, input int n_in, input int n_lvl);
    rows_t cur;
    rows_t nxt;
    int    cnt;
    int    grp;
    cur = in_rows;
    cnt = n_in;
    for (int l = 0; l < NLVL; l++) begin
      if (l < n_lvl) begin
        nxt = '0;
        grp = cnt / 3;
        for (int g = 0; g < NROW / 3; g++) begin
          if (g < grp) begin
            nxt[2*g]   = cur[3*g] ^ cur[3*g+1] ^ cur[3*g+2];
            nxt[2*g+1] = ((cur[3*g] & cur[3*g+1]) |
                          (cur[3*g] & cur[3*g+2]) |
                          (cur[3*g+1] & cur[3*g+2])) << 1;
          end
        end
        for (int j = 0; j < NROW; j++) begin
          if (j >= 3 * grp && j < cnt) nxt[j-grp] = cur[j];
        end
        cur = nxt;
        cnt = cnt - grp;
      end
    end
    return cur;
  endfunction

  // ---------------------------------------------------------------- state
  logic                     s1_vld_q, s1_vld_d;
  logic [NPP-1:0][PW-1:0]   pp_q, pp_d;
  logic [PW-1:0]            cin_q, cin_d;
`ifdef MUL_NNBIT_WALLACE_PIPE_SPLIT_EN
  logic                     mid_vld_q, mid_vld_d;
  rows_t                    mid_q, mid_d;
`endif
  logic                     s2_vld_q, s2_vld_d;
  logic [PW-1:0]            sum_q, sum_d;
  logic [PW-1:0]            carry_q, carry_d;
  logic                     out_vld_q, out_vld_d;
  logic [PW-1:0]            res_q, res_d;

  logic                     stall;
  logic [PW-1:0]            x_ext;
  logic [W+2:0]             y_ext;
  logic [2:0]               trip;
  logic                     neg, one, two;
  logic [PW-1:0]            mag;
  logic [NPP-1:0][PW-1:0]   pp_new;
  logic [PW-1:0]            cin_new;
  rows_t                    rows_s1;
  rows_t                    rows_fin;

  // A full output register that downstream refuses freezes every stage.
  assign stall   = out_vld_q & ~i_ready;
  assign o_ready = ~stall;
  assign o_valid = out_vld_q;
  assign o_res   = res_q;
`ifdef MUL_NNBIT_WALLACE_PIPE_SPLIT_EN
  assign o_busy  = s1_vld_q | mid_vld_q | s2_vld_q | out_vld_q;
`else
  assign o_busy  = s1_vld_q | s2_vld_q | out_vld_q;
`endif

  // ---------------------------------------------------------------- S1: Booth encode
  always_comb begin
    x_ext   = {{W{i_sign & i_num_x[W-1]}}, i_num_x};
    y_ext   = {{2{i_sign & i_num_y[W-1]}}, i_num_y, 1'b0};
    pp_new  = '0;
    cin_new = '0;
    trip    = '0;
    neg     = 1'b0;
    one     = 1'b0;
    two     = 1'b0;
    mag     = '0;
    for (int k = 0; k < NPP; k++) begin
      trip = y_ext[2*k +: 3];
      // digit = -2*b2 + b1 + b0; 000 and 111 both encode zero
      neg  = trip[2] & ~(trip[1] & trip[0]);
      one  = trip[1] ^ trip[0];
      two  = (trip[2] & ~trip[1] & ~trip[0]) | (~trip[2] & trip[1] & trip[0]);
      mag  = one ? x_ext : (two ? (x_ext << 1) : '0);
      // -m<<2k == (~m)<<2k + 2^2k, so the +1 lands at bit 2k of the carry-in row
      pp_new[k]      = (neg ? ~mag : mag) << (2 * k);
      cin_new[2*k]   = neg;
    end
  end

  // ---------------------------------------------------------------- S2: Wallace tree
  always_comb begin
    rows_s1 = '0;
    for (int k = 0; k < NPP; k++) rows_s1[k] = pp_q[k];
    rows_s1[NPP] = cin_q;
`ifdef MUL_NNBIT_WALLACE_PIPE_SPLIT_EN
    mid_d     = stall ? mid_q : compress(rows_s1, NROW, NLVL_A);
    mid_vld_d = stall ? mid_vld_q : s1_vld_q;
    rows_fin  = compress(mid_q, NROW_MID, NLVL - NLVL_A);
    s2_vld_d  = stall ? s2_vld_q : mid_vld_q;
`else
    rows_fin  = compress(rows_s1, NROW, NLVL);
    s2_vld_d  = stall ? s2_vld_q : s1_vld_q;
`endif
  end

  // ---------------------------------------------------------------- next-state
  always_comb begin
    s1_vld_d  = stall ? s1_vld_q : i_valid;
    pp_d      = stall ? pp_q     : pp_new;
    cin_d     = stall ? cin_q    : cin_new;
    sum_d     = stall ? sum_q    : rows_fin[0];
    carry_d   = stall ? carry_q  : rows_fin[1];
    out_vld_d = stall ? out_vld_q : s2_vld_q;
    // o_res keeps its last value when a bubble reaches the output stage
    res_d     = (!stall && s2_vld_q) ? (sum_q + carry_q) : res_q;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_vld_q  <= 1'b0;
`ifdef MUL_NNBIT_WALLACE_PIPE_SPLIT_EN
      mid_vld_q <= 1'b0;
`endif
      s2_vld_q  <= 1'b0;
      out_vld_q <= 1'b0;
      res_q     <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
`ifdef MUL_NNBIT_WALLACE_PIPE_SPLIT_EN
      mid_vld_q <= mid_vld_d;
`endif
      s2_vld_q  <= s2_vld_d;
      out_vld_q <= out_vld_d;
      res_q     <= res_d;
    end
  end

  // Stage data is qualified by its valid bit, so it needs no reset.
  always_ff @(posedge i_clk) begin
    pp_q    <= pp_d;
    cin_q   <= cin_d;
`ifdef MUL_NNBIT_WALLACE_PIPE_SPLIT_EN
    mid_q   <= mid_d;
`endif
    sum_q   <= sum_d;
    carry_q <= carry_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_nnbit_wallace_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_mul_nnbit_wallace_pipe                                        |
// | Purpose : Self-checking bench for mul_nnbit_wallace_pipe (W=16): directed  |
// |           vector table, latency, random stream, back-pressure and          |
// |           mid-flight reset, against an arithmetic reference model.         |
// | Config  : honours MUL_NNBIT_WALLACE_PIPE_SPLIT_EN for expected latency.    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_mul_nnbit_wallace_pipe;

  localparam int W = 16;
`ifdef MUL_NNBIT_WALLACE_PIPE_SPLIT_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic           i_clk = 1'b0;
  logic           i_rst_n = 1'b0;
  logic           i_valid = 1'b0;
  logic           o_ready;
  logic           i_sign = 1'b0;
  logic [W-1:0]   i_num_x = '0;
  logic [W-1:0]   i_num_y = '0;
  logic           o_valid;
  logic           i_ready = 1'b1;
  logic [2*W-1:0] o_res;
  logic           o_busy;

  mul_nnbit_wallace_pipe #(.DATA_WIDTH(W)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_sign  (i_sign),
    .i_num_x (i_num_x),
    .i_num_y (i_num_y),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_res   (o_res),
    .o_busy  (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_out    = 0;
  logic [2*W-1:0] exp_q[$];
  logic           smp_valid, smp_ready;
  logic [2*W-1:0] smp_res;

  typedef struct {
    logic           s;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic [2*W-1:0] e;
  } vec_t;
  vec_t tbl[10];

  // Reference: plain integer multiply of the operands as interpreted by mode.
  function automatic logic [2*W-1:0] model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    longint      sx, sy;
    logic [63:0] p;
    sx = s ? longint'($signed(x)) : longint'($unsigned(x));
    sy = s ? longint'($signed(y)) : longint'($unsigned(y));
    p  = 64'(sx * sy);
    return p[2*W-1:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // One handshake cycle: drive at negedge, sample just after, score transfers.
  task automatic cycle(input logic v, input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [2*W-1:0] e, input logic rdy);
    @(negedge i_clk);
    i_valid = v; i_sign = s; i_num_x = x; i_num_y = y; i_ready = rdy;
    #1;
    smp_valid = o_valid; smp_ready = o_ready; smp_res = o_res;
    if (o_valid && i_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_out: got %0h required no output at %0t", o_res, $time);
      end else begin
        chk("res", o_res, exp_q.pop_front());
      end
    end
    if (i_valid && o_ready) exp_q.push_back(e);
  endtask

  task automatic rand_op(input logic v, input logic rdy);
    logic         s;
    logic [W-1:0] x, y;
    s = 1'($urandom_range(0, 1));
    x = W'($urandom);
    y = W'($urandom);
    case ($urandom_range(0, 7))
      0: x = '0;
      1: y = {1'b1, {(W-1){1'b0}}};
      2: x = '1;
      3: y = {1'b0, {(W-1){1'b1}}};
      default: ;
    endcase
    cycle(v, s, x, y, model(s, x, y), rdy);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < LAT + 4; i++) begin
      if (exp_q.size() != 0) cycle(1'b0, 1'b0, '0, '0, '0, 1'b1);
    end
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int base;

    tbl[0] = '{1'b1, 16'hFFFD, 16'h0007, 32'hFFFF_FFEB};
    tbl[1] = '{1'b1, 16'h8000, 16'h8000, 32'h4000_0000};
    tbl[2] = '{1'b0, 16'h8000, 16'h8000, 32'h4000_0000};
    tbl[3] = '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
    tbl[4] = '{1'b1, 16'h0000, 16'h1234, 32'h0000_0000};
    tbl[5] = '{1'b0, 16'hABCD, 16'h0000, 32'h0000_0000};
    tbl[6] = '{1'b1, 16'hFFFF, 16'hFFFF, 32'h0000_0001};
    tbl[7] = '{1'b1, 16'h7FFF, 16'h8000, 32'hC000_8000};
    tbl[8] = '{1'b0, 16'hFFFF, 16'h0002, 32'h0001_FFFE};
    tbl[9] = '{1'b1, 16'h0003, 16'hFFFB, 32'hFFFF_FFF1};

    // Reset state
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_res", o_res, 0);
    chk("rst_busy", o_busy, 0);
    i_rst_n = 1'b1;
    #1;
    chk("rst_ready", o_ready, 1);

    // Latency of a single operation
    @(negedge i_clk);
    i_valid = 1'b1; i_sign = tbl[0].s; i_num_x = tbl[0].x; i_num_y = tbl[0].y; i_ready = 1'b1;
    #1;
    chk("lat_accept_ready", o_ready, 1);
    @(negedge i_clk);
    i_valid = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      if (k > 1) @(negedge i_clk);
      #1;
      chk("lat_valid", o_valid, (k == LAT) ? 1 : 0);
    end
    chk("lat_res", o_res, tbl[0].e);
    cycle(1'b0, 1'b0, '0, '0, '0, 1'b1);
    chk("lat_single_out", smp_valid, 0);

    // Directed table, streamed back to back
    for (int i = 0; i < 10; i++) cycle(1'b1, tbl[i].s, tbl[i].x, tbl[i].y, tbl[i].e, 1'b1);
    drain("tbl_drain");

    // 100 random back-to-back ops: one result per cycle once full
    base = n_out;
    for (int i = 0; i < 100; i++) rand_op(1'b1, 1'b1);
    chk("stream_rate", n_out - base, 100 - LAT);
    drain("stream_drain");

    // Random valid / ready mix
    for (int i = 0; i < 300; i++) rand_op(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
    drain("mix_drain");

    // Back-pressure with three ops in flight
    for (int i = 0; i < 3; i++) rand_op(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      rand_op(1'b1, 1'b0);
      chk("bp_ready", smp_ready, 0);
      chk("bp_valid", smp_valid, 1);
      chk("bp_res_stable", smp_res, exp_q[0]);
      chk("bp_busy", o_busy, 1);
    end
    base = n_out;
    for (int i = 0; i < LAT + 2; i++) cycle(1'b0, 1'b0, '0, '0, '0, 1'b1);
    chk("bp_count", n_out - base, 3);
    chk("bp_empty", exp_q.size(), 0);
    chk("bp_idle_busy", o_busy, 0);

    // Reset with two ops in flight
    for (int i = 0; i < 2; i++) rand_op(1'b1, 1'b1);
    @(negedge i_clk);
    i_rst_n = 1'b0; i_valid = 1'b0;
    @(negedge i_clk);
    #1;
    chk("mrst_valid", o_valid, 0);
    chk("mrst_res", o_res, 0);
    chk("mrst_busy", o_busy, 0);
    i_rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < LAT + 5; i++) begin
      cycle(1'b0, 1'b0, '0, '0, '0, 1'b1);
      chk("mrst_no_stale", smp_valid, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
